pipe_reg_bank: RTL and testbench

- Parametrised multi-channel load register with a configurable-depth delay pipeline per channel.
- Successor to the fixed two-stage, dual-output register.
- Adds independent per-channel load, global stall and flush, a per-stage fresh-data flag, and optional parity checking.
- Sits between datapath producers and downstream consumers that need a value held and delivered a fixed number of cycles later.

---
 rtl/pipe_reg_bank.sv | 94 +++++++++
 tb/tb_pipe_reg_bank.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_reg_bank.sv
// pipe_reg_bank: per-channel holding register feeding a DEPTH-stage delay line with fresh flags.
// Define PIPE_REG_BANK_PARITY_EN to add even parity per stage and a sticky parity_err output.
module pipe_reg_bank #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned NUM_PORTS  = 2,
    parameter int unsigned DEPTH      = 2
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [NUM_PORTS-1:0]            load,
    input  logic                            stall,
    input  logic                            flush,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0] data_in,
    output logic [NUM_PORTS*DATA_WIDTH-1:0] data_out,
    output logic [NUM_PORTS-1:0]            fresh_out,
`ifdef PIPE_REG_BANK_PARITY_EN
    output logic [NUM_PORTS-1:0]            parity_err,
`endif
    output logic [NUM_PORTS*DATA_WIDTH-1:0] hold_out
);

    logic [NUM_PORTS-1:0][DATA_WIDTH-1:0]            hold_q;
    logic [NUM_PORTS-1:0][DEPTH-1:0][DATA_WIDTH-1:0] stage_q;
    logic [NUM_PORTS-1:0][DEPTH-1:0]                 fresh_q;
    logic [NUM_PORTS-1:0][DATA_WIDTH-1:0]            s0_d;

    // Value entering stage 0: a new load, otherwise the held value recirculates.
    always_comb begin
        s0_d = '0;
        for (int unsigned c = 0; c < NUM_PORTS; c++) begin
            s0_d[c] = load[c] ? data_in[c*DATA_WIDTH +: DATA_WIDTH] : hold_q[c];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hold_q  <= '0;
            stage_q <= '0;
            fresh_q <= '0;
        end else if (flush) begin
            fresh_q <= '0;
        end else if (!stall) begin
            for (int unsigned c = 0; c < NUM_PORTS; c++) begin
                if (load[c]) begin
                    hold_q[c] <= data_in[c*DATA_WIDTH +: DATA_WIDTH];
                end
                stage_q[c][0] <= s0_d[c];
                fresh_q[c][0] <= load[c];
                for (int unsigned k = 1; k < DEPTH; k++) begin
                    stage_q[c][k] <= stage_q[c][k-1];
                    fresh_q[c][k] <= fresh_q[c][k-1];
                end
            end
        end
    end

`ifdef PIPE_REG_BANK_PARITY_EN
    logic [NUM_PORTS-1:0][DEPTH-1:0] par_q;
    logic [NUM_PORTS-1:0]            perr_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            par_q  <= '0;
            perr_q <= '0;
        end else if (flush) begin
            perr_q <= '0;
        end else if (!stall) begin
            for (int unsigned c = 0; c < NUM_PORTS; c++) begin
                par_q[c][0] <= ^s0_d[c];
                for (int unsigned k = 1; k < DEPTH; k++) begin
                    par_q[c][k] <= par_q[c][k-1];
                end
                if ((^stage_q[c][DEPTH-1]) != par_q[c][DEPTH-1]) begin
                    perr_q[c] <= 1'b1;
                end
            end
        end
    end

    assign parity_err = perr_q;
`endif

    always_comb begin
        data_out  = '0;
        hold_out  = '0;
        fresh_out = '0;
        for (int unsigned c = 0; c < NUM_PORTS; c++) begin
            data_out[c*DATA_WIDTH +: DATA_WIDTH] = stage_q[c][DEPTH-1];
            hold_out[c*DATA_WIDTH +: DATA_WIDTH] = hold_q[c];
            fresh_out[c]                         = fresh_q[c][DEPTH-1];
        end
    end

endmodule

// File: tb/tb_pipe_reg_bank.sv
// Self-checking bench for pipe_reg_bank: directed literal checks plus random traffic against
// a history-log model of the per-channel delay line.
module tb_pipe_reg_bank;
    localparam int DW = 32;
    localparam int NP = 2;
    localparam int D  = 2;

    logic               clk = 1'b0;
    logic               reset;
    logic [NP-1:0]      load = '0;
    logic               stall = 1'b0;
    logic               flush = 1'b0;
    logic [NP*DW-1:0]   data_in = '0;
    logic [NP*DW-1:0]   data_out;
    logic [NP-1:0]      fresh_out;
    logic [NP*DW-1:0]   hold_out;
`ifdef PIPE_REG_BANK_PARITY_EN
    logic [NP-1:0]      parity_err;
`endif

    pipe_reg_bank #(
        .DATA_WIDTH (DW),
        .NUM_PORTS  (NP),
        .DEPTH      (D)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .load       (load),
        .stall      (stall),
        .flush      (flush),
        .data_in    (data_in),
        .data_out   (data_out),
        .fresh_out  (fresh_out),
`ifdef PIPE_REG_BANK_PARITY_EN
        .parity_err (parity_err),
`endif
        .hold_out   (hold_out)
    );

    always #5 clk = ~clk;

    // One log entry per advancing edge: what entered stage 0 on every channel.
    typedef struct packed {
        logic [NP*DW-1:0] d;
        logic [NP-1:0]    f;
    } ent_t;

    ent_t             hist[$];
    logic [NP*DW-1:0] m_hold = '0;
    logic [NP-1:0]    m_perr = '0;
    bit               cmp_en = 1'b0;
    bit               par_skip = 1'b0;
    int               n_chk = 0;
    int               n_fail = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %h required %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        hist.delete();
        m_hold = '0;
        m_perr = '0;
    endfunction

    function automatic void model_edge();
        ent_t e;
        e = '0;
        if (!reset) begin
            model_reset();
        end else if (flush) begin
            foreach (hist[i]) hist[i].f = '0;
            m_perr = '0;
        end else if (!stall) begin
            for (int c = 0; c < NP; c++) begin
                if (load[c]) m_hold[c*DW +: DW] = data_in[c*DW +: DW];
                e.d[c*DW +: DW] = m_hold[c*DW +: DW];
                e.f[c] = load[c];
            end
            hist.push_back(e);
            if (hist.size() > D) void'(hist.pop_front());
        end
    endfunction

    // Output is the entry written D advancing edges ago, or all-zero if none yet.
    function automatic ent_t exp_out();
        if (hist.size() >= D) return hist[hist.size() - D];
        return '0;
    endfunction

    always @(negedge clk) begin
        if (cmp_en) begin
            ent_t e;
            e = exp_out();
            chk("data_out", data_out, e.d);
            chk("fresh_out", 64'(fresh_out), 64'(e.f));
            chk("hold_out", hold_out, m_hold);
`ifdef PIPE_REG_BANK_PARITY_EN
            if (!par_skip) chk("parity_err", 64'(parity_err), 64'(m_perr));
`endif
        end
    end

    task automatic cyc(input logic [NP-1:0] ld, input logic st, input logic fl,
                       input logic [NP*DW-1:0] din);
        load    = ld;
        stall   = st;
        flush   = fl;
        data_in = din;
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc('0, 1'b0, 1'b0, {$urandom, $urandom});
    endtask

`ifdef PIPE_REG_BANK_PARITY_EN
    logic [NP*D-1:0] par_tmp;
`endif

    initial begin
        reset = 1'b1;
        #1 reset = 1'b0;
        #1 cmp_en = 1'b1;

        // Reset held with loads active: everything stays zero.
        for (int i = 0; i < 3; i++) cyc('1, 1'b0, 1'b0, {32'h12345678, 32'h9abcdef0});
        chk("rst_data", data_out, 64'h0);
        chk("rst_hold", hold_out, 64'h0);
        chk("rst_fresh", 64'(fresh_out), 64'h0);
        reset = 1'b1;
        idle(3);
        chk("post_rst_data", data_out, 64'h0);
        chk("post_rst_hold", hold_out, 64'h0);

        // Latency through a 2-deep pipe.
        cyc(2'b01, 1'b0, 1'b0, {32'h0, 32'hDEADBEEF});
        chk("lat_hold_c1", 64'(hold_out[31:0]), 64'hDEADBEEF);
        cyc('0, 1'b0, 1'b0, '0);
        chk("lat_data_c2", 64'(data_out[31:0]), 64'hDEADBEEF);
        chk("lat_fresh_c2", 64'(fresh_out[0]), 64'h1);
        cyc('0, 1'b0, 1'b0, '0);
        chk("lat_data_c3", 64'(data_out[31:0]), 64'hDEADBEEF);
        chk("lat_fresh_c3", 64'(fresh_out[0]), 64'h0);

        // Channel independence and back-to-back loads.
        cyc(2'b01, 1'b0, 1'b0, {32'h0, 32'h1});
        cyc(2'b11, 1'b0, 1'b0, {32'hA, 32'h2});
        chk("ind_c2_d0", 64'(data_out[31:0]), 64'h1);
        chk("ind_c2_f", 64'(fresh_out), 64'h1);
        cyc(2'b01, 1'b0, 1'b0, {32'h0, 32'h3});
        chk("ind_c3_d0", 64'(data_out[31:0]), 64'h2);
        chk("ind_c3_d1", 64'(data_out[63:32]), 64'hA);
        chk("ind_c3_f", 64'(fresh_out), 64'h3);
        cyc('0, 1'b0, 1'b0, '0);
        chk("ind_c4_d0", 64'(data_out[31:0]), 64'h3);
        chk("ind_c4_f", 64'(fresh_out), 64'h1);
        chk("ind_c4_d1", 64'(data_out[63:32]), 64'hA);

        // Stall adds one cycle and ignores the load presented during it.
        cyc(2'b01, 1'b0, 1'b0, {32'h0, 32'h55});
        cyc(2'b01, 1'b1, 1'b0, {32'h0, 32'h99});
        chk("stall_hold", 64'(hold_out[31:0]), 64'h55);
        chk("stall_fresh", 64'(fresh_out[0]), 64'h0);
        cyc('0, 1'b0, 1'b0, '0);
        chk("stall_data", 64'(data_out[31:0]), 64'h55);
        chk("stall_fresh_c3", 64'(fresh_out[0]), 64'h1);
        chk("stall_hold_c3", 64'(hold_out[31:0]), 64'h55);

        // Flush: data stays, fresh cleared. Pipe pre-filled with 0x77 so data_out reads 0x77.
        cyc(2'b01, 1'b0, 1'b0, {32'h0, 32'h77});
        idle(D);
        cyc(2'b01, 1'b0, 1'b0, {32'h0, 32'h77});
        cyc(2'b01, 1'b0, 1'b1, {32'h0, 32'h88});
        chk("flush_data", 64'(data_out[31:0]), 64'h77);
        chk("flush_fresh", 64'(fresh_out), 64'h0);
        chk("flush_hold", 64'(hold_out[31:0]), 64'h77);
        cyc('0, 1'b0, 1'b0, '0);
        chk("flush_fresh_c3", 64'(fresh_out), 64'h0);

        // Asynchronous reset mid-flight.
        cyc(2'b11, 1'b0, 1'b0, {32'h31, 32'h31});
        reset = 1'b0;
        model_reset();
        #1;
        chk("arst_data", data_out, 64'h0);
        chk("arst_hold", hold_out, 64'h0);
        chk("arst_fresh", 64'(fresh_out), 64'h0);
        idle(1);
        reset = 1'b1;
        idle(2);

        // Random traffic against the model.
        for (int i = 0; i < 400; i++) begin
            cyc(NP'($urandom), ($urandom_range(7) == 0), ($urandom_range(15) == 0),
                {$urandom, $urandom});
        end

`ifdef PIPE_REG_BANK_PARITY_EN
        // Corrupt channel 0's last-stage parity bit for one edge.
        cyc(2'b11, 1'b0, 1'b0, {32'h0F0F0F0F, 32'h01234567});
        idle(D);
        par_skip = 1'b1;
        par_tmp = dut.par_q;
        force dut.par_q = par_tmp ^ ((NP*D)'(1) << (D - 1));
        idle(1);
        chk("perr_set", 64'(parity_err[0]), 64'h1);
        release dut.par_q;
        idle(D + 2);
        chk("perr_sticky", 64'(parity_err[0]), 64'h1);
        cyc('0, 1'b0, 1'b1, '0);
        chk("perr_flush", 64'(parity_err), 64'h0);
        par_skip = 1'b0;
        idle(3);
        chk("perr_after", 64'(parity_err), 64'h0);
`endif

        cmp_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: actual running required finished");
        $fatal(1);
    end

endmodule
